// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// ex_stage : RV32IM execute stage - forwarding, ALU, iterative mul/div, branch
// Revision : 1.0
// ============================================================================
module ex_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  EX_valid_i,
    input  logic                  EX_flush_i,
    input  logic [DATA_WIDTH-1:0] EX_pc_i,
    input  logic [DATA_WIDTH-1:0] EX_rs1_data_i,
    input  logic [DATA_WIDTH-1:0] EX_rs2_data_i,
    input  logic [DATA_WIDTH-1:0] EX_imm_i,
    input  logic [1:0]            EX_fwd_a_i,
    input  logic [1:0]            EX_fwd_b_i,
    input  logic                  EX_use_imm_i,
    input  logic [4:0]            EX_alu_op_i,
    input  logic [2:0]            EX_br_op_i,
    input  logic [DATA_WIDTH-1:0] WB_data_i,
    input  logic [4:0]            EX_rd_add_i,
    input  logic                  EX_regwrite_i,
    input  logic [3:0]            EX_mem_op_i,
    input  logic                  EX_RD_mem_i,
    input  logic                  EX_WR_mem_i,
    input  logic [1:0]            EX_sel_to_reg_i,
    output logic [DATA_WIDTH-1:0] EX_alu_result_o,
    output logic [DATA_WIDTH-1:0] EX_rs2_data_o,
    output logic [4:0]            EX_rd_add_o,
    output logic                  EX_regwrite_o,
    output logic [3:0]            EX_mem_op_o,
    output logic                  EX_RD_mem_o,
    output logic                  EX_WR_mem_o,
    output logic [1:0]            EX_sel_to_reg_o,
    output logic [DATA_WIDTH-1:0] EX_pc_o,
    output logic [DATA_WIDTH-1:0] EX_imm_o,
    output logic                  EX_br_taken_o,
    output logic [DATA_WIDTH-1:0] EX_br_target_o,
    output logic                  EX_busy_o
);

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_SLL   = 5'd2;
    localparam logic [4:0] OP_SLT   = 5'd3;
    localparam logic [4:0] OP_SLTU  = 5'd4;
    localparam logic [4:0] OP_XOR   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_OR    = 5'd8;
    localparam logic [4:0] OP_AND   = 5'd9;
    localparam logic [4:0] OP_PASSB = 5'd10;
    localparam logic [4:0] OP_MUL   = 5'd16;
    localparam logic [4:0] OP_MULHU = 5'd17;
    localparam logic [4:0] OP_DIV   = 5'd18;
    localparam logic [4:0] OP_DIVU  = 5'd19;
    localparam logic [4:0] OP_REM   = 5'd20;
    localparam logic [4:0] OP_REMU  = 5'd21;

    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;
    localparam logic [2:0] BR_BLTU = 3'd5;
    localparam logic [2:0] BR_BGEU = 3'd6;

    localparam int MSB = DATA_WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] op_a, fwd_b, op_b, alu_res, md_res;
    logic [DATA_WIDTH-1:0] md_hi_q, md_hi_d, md_lo_q, md_lo_d, md_b_q, md_b_d;
    logic [4:0]            md_op_q, md_op_d, cnt_q, cnt_d;
    logic                  q_neg_q, q_neg_d, r_neg_q, r_neg_d, div0_q, div0_d;
    logic                  busy, br_cond, start_md, is_sdiv, a_neg, b_neg, md_is_div;
    logic [DATA_WIDTH:0]   mul_sum, div_shift;
    logic [DATA_WIDTH+1:0] div_diff;
    logic [DATA_WIDTH-1:0] q_fix, r_fix;

    // Output pipeline registers
    logic [DATA_WIDTH-1:0] alu_result_q, alu_result_d, rs2_data_q, rs2_data_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d, imm_q, imm_d;
    logic [4:0]            rd_add_q, rd_add_d;
    logic                  regwrite_q, regwrite_d, rd_mem_q, rd_mem_d, wr_mem_q, wr_mem_d;
    logic [3:0]            mem_op_q, mem_op_d;
    logic [1:0]            sel_to_reg_q, sel_to_reg_d;
    logic                  load_alu, load_md;

    always_comb begin
        op_a = EX_rs1_data_i;
        case (EX_fwd_a_i)
            2'd1:    op_a = alu_result_q;
            2'd2:    op_a = WB_data_i;
            2'd3:    op_a = EX_pc_i;
            default: op_a = EX_rs1_data_i;
        endcase
        fwd_b = EX_rs2_data_i;
        case (EX_fwd_b_i)
            2'd1:    fwd_b = alu_result_q;
            2'd2:    fwd_b = WB_data_i;
            default: fwd_b = EX_rs2_data_i;
        endcase
        op_b = EX_use_imm_i ? EX_imm_i : fwd_b;
    end

    always_comb begin
        alu_res = '0;
        case (EX_alu_op_i)
            OP_ADD:   alu_res = op_a + op_b;
            OP_SUB:   alu_res = op_a - op_b;
            OP_SLL:   alu_res = op_a << op_b[4:0];
            OP_SLT:   alu_res = {{MSB{1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU:  alu_res = {{MSB{1'b0}}, (op_a < op_b)};
            OP_XOR:   alu_res = op_a ^ op_b;
            OP_SRL:   alu_res = op_a >> op_b[4:0];
            OP_SRA:   alu_res = $signed(op_a) >>> op_b[4:0];
            OP_OR:    alu_res = op_a | op_b;
            OP_AND:   alu_res = op_a & op_b;
            OP_PASSB: alu_res = op_b;
            default:  alu_res = '0;
        endcase
    end

    // Branches compare forwarded A against forwarded rs2, never the immediate
    always_comb begin
        br_cond = 1'b0;
        case (EX_br_op_i)
            BR_BEQ:  br_cond = (op_a == fwd_b);
            BR_BNE:  br_cond = (op_a != fwd_b);
            BR_BLT:  br_cond = ($signed(op_a) < $signed(fwd_b));
            BR_BGE:  br_cond = ($signed(op_a) >= $signed(fwd_b));
            BR_BLTU: br_cond = (op_a < fwd_b);
            BR_BGEU: br_cond = (op_a >= fwd_b);
            default: br_cond = 1'b0;
        endcase
    end

    assign EX_br_taken_o  = EX_valid_i & ~EX_flush_i & ~busy & br_cond;
    assign EX_br_target_o = EX_pc_i + EX_imm_i;
    assign EX_busy_o      = busy;

    assign start_md  = EX_valid_i & ~EX_flush_i & EX_alu_op_i[4] & (state_q == S_IDLE);
    assign is_sdiv   = (EX_alu_op_i == OP_DIV) | (EX_alu_op_i == OP_REM);
    assign a_neg     = is_sdiv & op_a[MSB];
    assign b_neg     = is_sdiv & op_b[MSB];
    assign md_is_div = (md_op_q >= OP_DIV) && (md_op_q <= OP_REMU);

    // One shift-add or restoring-subtract step; lo doubles as multiplier / quotient
    assign mul_sum   = {1'b0, md_hi_q} + (md_lo_q[0] ? {1'b0, md_b_q} : '0);
    assign div_shift = {md_hi_q, md_lo_q[MSB]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, md_b_q};

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        md_hi_d = md_hi_q;
        md_lo_d = md_lo_q;
        md_b_d  = md_b_q;
        md_op_d = md_op_q;
        cnt_d   = cnt_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        div0_d  = div0_q;
        case (state_q)
            S_IDLE: begin
                if (start_md) begin
                    busy    = 1'b1;
                    state_d = S_CALC;
                    md_hi_d = '0;
                    md_lo_d = a_neg ? -op_a : op_a;
                    md_b_d  = b_neg ? -op_b : op_b;
                    md_op_d = EX_alu_op_i;
                    cnt_d   = '0;
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = a_neg;
                    div0_d  = (op_b == '0);
                end
            end
            S_CALC: begin
                busy  = 1'b1;
                cnt_d = cnt_q + 5'd1;
                if (md_is_div) begin
                    if (div_diff[DATA_WIDTH+1]) begin
                        md_hi_d = div_shift[MSB:0];
                        md_lo_d = {md_lo_q[MSB-1:0], 1'b0};
                    end else begin
                        md_hi_d = div_diff[MSB:0];
                        md_lo_d = {md_lo_q[MSB-1:0], 1'b1};
                    end
                end else begin
                    md_hi_d = mul_sum[DATA_WIDTH:1];
                    md_lo_d = {mul_sum[0], md_lo_q[MSB:1]};
                end
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (EX_flush_i) begin
            state_d = S_IDLE;
            busy    = 1'b0;
            cnt_d   = '0;
        end
    end

    // Divide-by-zero quotient is all ones regardless of dividend sign
    always_comb begin
        q_fix  = div0_q ? '1 : (q_neg_q ? -md_lo_q : md_lo_q);
        r_fix  = r_neg_q ? -md_hi_q : md_hi_q;
        md_res = '0;
        case (md_op_q)
            OP_MUL:            md_res = md_lo_q;
            OP_MULHU:          md_res = md_hi_q;
            OP_DIV, OP_DIVU:   md_res = q_fix;
            OP_REM, OP_REMU:   md_res = r_fix;
            default:           md_res = '0;
        endcase
    end

    assign load_alu = EX_valid_i & ~EX_flush_i & (state_q == S_IDLE) & ~EX_alu_op_i[4];
    assign load_md  = EX_valid_i & ~EX_flush_i & (state_q == S_DONE);

    always_comb begin
        alu_result_d = '0;
        rs2_data_d   = '0;
        pc_d         = '0;
        imm_d        = '0;
        rd_add_d     = '0;
        regwrite_d   = 1'b0;
        mem_op_d     = '0;
        rd_mem_d     = 1'b0;
        wr_mem_d     = 1'b0;
        sel_to_reg_d = '0;
        if (load_alu || load_md) begin
            alu_result_d = load_md ? md_res : alu_res;
            rs2_data_d   = fwd_b;
            pc_d         = EX_pc_i;
            imm_d        = EX_imm_i;
            rd_add_d     = EX_rd_add_i;
            regwrite_d   = EX_regwrite_i;
            mem_op_d     = EX_mem_op_i;
            rd_mem_d     = EX_RD_mem_i;
            wr_mem_d     = EX_WR_mem_i;
            sel_to_reg_d = EX_sel_to_reg_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            md_hi_q      <= '0;
            md_lo_q      <= '0;
            md_b_q       <= '0;
            md_op_q      <= '0;
            cnt_q        <= '0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            div0_q       <= 1'b0;
            alu_result_q <= '0;
            rs2_data_q   <= '0;
            pc_q         <= '0;
            imm_q        <= '0;
            rd_add_q     <= '0;
            regwrite_q   <= 1'b0;
            mem_op_q     <= '0;
            rd_mem_q     <= 1'b0;
            wr_mem_q     <= 1'b0;
            sel_to_reg_q <= '0;
        end else begin
            state_q      <= state_d;
            md_hi_q      <= md_hi_d;
            md_lo_q      <= md_lo_d;
            md_b_q       <= md_b_d;
            md_op_q      <= md_op_d;
            cnt_q        <= cnt_d;
            q_neg_q      <= q_neg_d;
            r_neg_q      <= r_neg_d;
            div0_q       <= div0_d;
            alu_result_q <= alu_result_d;
            rs2_data_q   <= rs2_data_d;
            pc_q         <= pc_d;
            imm_q        <= imm_d;
            rd_add_q     <= rd_add_d;
            regwrite_q   <= regwrite_d;
            mem_op_q     <= mem_op_d;
            rd_mem_q     <= rd_mem_d;
            wr_mem_q     <= wr_mem_d;
            sel_to_reg_q <= sel_to_reg_d;
        end
    end

    assign EX_alu_result_o = alu_result_q;
    assign EX_rs2_data_o   = rs2_data_q;
    assign EX_pc_o         = pc_q;
    assign EX_imm_o        = imm_q;
    assign EX_rd_add_o     = rd_add_q;
    assign EX_regwrite_o   = regwrite_q;
    assign EX_mem_op_o     = mem_op_q;
    assign EX_RD_mem_o     = rd_mem_q;
    assign EX_WR_mem_o     = wr_mem_q;
    assign EX_sel_to_reg_o = sel_to_reg_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// tb_ex_stage : scoreboard bench for the execute stage
// Revision    : 1.0
// ============================================================================
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        EX_valid_i, EX_flush_i, EX_use_imm_i;
    logic [31:0] EX_pc_i, EX_rs1_data_i, EX_rs2_data_i, EX_imm_i, WB_data_i;
    logic [1:0]  EX_fwd_a_i, EX_fwd_b_i, EX_sel_to_reg_i;
    logic [4:0]  EX_alu_op_i, EX_rd_add_i;
    logic [2:0]  EX_br_op_i;
    logic        EX_regwrite_i, EX_RD_mem_i, EX_WR_mem_i;
    logic [3:0]  EX_mem_op_i;
    logic [31:0] EX_alu_result_o, EX_rs2_data_o, EX_pc_o, EX_imm_o, EX_br_target_o;
    logic [4:0]  EX_rd_add_o;
    logic        EX_regwrite_o, EX_RD_mem_o, EX_WR_mem_o, EX_br_taken_o, EX_busy_o;
    logic [3:0]  EX_mem_op_o;
    logic [1:0]  EX_sel_to_reg_o;

    always #5 clk = ~clk;

    ex_stage #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .EX_valid_i(EX_valid_i), .EX_flush_i(EX_flush_i), .EX_pc_i(EX_pc_i),
        .EX_rs1_data_i(EX_rs1_data_i), .EX_rs2_data_i(EX_rs2_data_i), .EX_imm_i(EX_imm_i),
        .EX_fwd_a_i(EX_fwd_a_i), .EX_fwd_b_i(EX_fwd_b_i), .EX_use_imm_i(EX_use_imm_i),
        .EX_alu_op_i(EX_alu_op_i), .EX_br_op_i(EX_br_op_i), .WB_data_i(WB_data_i),
        .EX_rd_add_i(EX_rd_add_i), .EX_regwrite_i(EX_regwrite_i), .EX_mem_op_i(EX_mem_op_i),
        .EX_RD_mem_i(EX_RD_mem_i), .EX_WR_mem_i(EX_WR_mem_i), .EX_sel_to_reg_i(EX_sel_to_reg_i),
        .EX_alu_result_o(EX_alu_result_o), .EX_rs2_data_o(EX_rs2_data_o),
        .EX_rd_add_o(EX_rd_add_o), .EX_regwrite_o(EX_regwrite_o), .EX_mem_op_o(EX_mem_op_o),
        .EX_RD_mem_o(EX_RD_mem_o), .EX_WR_mem_o(EX_WR_mem_o), .EX_sel_to_reg_o(EX_sel_to_reg_o),
        .EX_pc_o(EX_pc_o), .EX_imm_o(EX_imm_o), .EX_br_taken_o(EX_br_taken_o),
        .EX_br_target_o(EX_br_target_o), .EX_busy_o(EX_busy_o)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] st;
        logic [13:0] ctrl;
        logic [31:0] pc;
        logic [31:0] imm;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] pc_cnt = 32'h0000_0100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: any non-bubble EX/MEM output must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && (EX_regwrite_o || EX_WR_mem_o)) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_output: got %h, expected no output", EX_alu_result_o);
            end else begin
                e = sb.pop_front();
                chk("result", EX_alu_result_o, e.res);
                chk("store_data", EX_rs2_data_o, e.st);
                chk("ctrl", {18'd0, EX_rd_add_o, EX_regwrite_o, EX_mem_op_o, EX_RD_mem_o,
                             EX_WR_mem_o, EX_sel_to_reg_o}, {18'd0, e.ctrl});
                chk("pc_imm", EX_pc_o ^ EX_imm_o, e.pc ^ e.imm);
            end
        end
    end

    task automatic drive(input logic [4:0] op, input logic [2:0] br, input logic [1:0] fa,
                         input logic [1:0] fb, input logic ui, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm, input logic [31:0] pc,
                         input logic [31:0] wb, input logic rw, input logic wrm);
        @(posedge clk);
        #1;
        EX_valid_i      = 1'b1;
        EX_flush_i      = 1'b0;
        EX_alu_op_i     = op;
        EX_br_op_i      = br;
        EX_fwd_a_i      = fa;
        EX_fwd_b_i      = fb;
        EX_use_imm_i    = ui;
        EX_rs1_data_i   = rs1;
        EX_rs2_data_i   = rs2;
        EX_imm_i        = imm;
        EX_pc_i         = pc;
        WB_data_i       = wb;
        EX_rd_add_i     = pc[6:2];
        EX_regwrite_i   = rw;
        EX_WR_mem_i     = wrm;
        EX_RD_mem_i     = 1'b0;
        EX_mem_op_i     = wrm ? 4'h2 : 4'h0;
        EX_sel_to_reg_i = rw ? 2'd1 : 2'd0;
    endtask

    task automatic push(input logic [31:0] res, input logic [31:0] st);
        exp_t x;
        x.res  = res;
        x.st   = st;
        x.ctrl = {EX_rd_add_i, EX_regwrite_i, EX_mem_op_i, EX_RD_mem_i, EX_WR_mem_i, EX_sel_to_reg_i};
        x.pc   = EX_pc_i;
        x.imm  = EX_imm_i;
        sb.push_back(x);
    endtask

    task automatic alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic ui, input logic [31:0] res);
        pc_cnt = pc_cnt + 32'd4;
        drive(op, 3'd0, 2'd0, 2'd0, ui, a, b, imm, pc_cnt, 32'h0, 1'b1, 1'b0);
        push(res, b);
    endtask

    task automatic md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res);
        int busy_cnt;
        int bub;
        pc_cnt = pc_cnt + 32'd4;
        drive(op, 3'd0, 2'd0, 2'd0, 1'b0, a, b, 32'h0, pc_cnt, 32'h0, 1'b1, 1'b0);
        push(res, b);
        busy_cnt = 0;
        bub      = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c > 0 && !EX_regwrite_o && !EX_WR_mem_o) bub++;
            if (EX_busy_o) busy_cnt++;
            else break;
        end
        chk("md_busy_cycles", 32'(busy_cnt), 32'd33);
        chk("md_bubbles", 32'(bub), 32'd33);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        EX_valid_i    = 1'b0;
        EX_flush_i    = 1'b0;
        EX_regwrite_i = 1'b0;
        EX_WR_mem_i   = 1'b0;
        EX_br_op_i    = 3'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(5'd0, 3'd0, 2'd0, 2'd0, 1'b0, 32'd5, 32'd6, 32'd7, 32'h40, 32'h0, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_result", EX_alu_result_o, 32'h0);
        chk("rst_store", EX_rs2_data_o, 32'h0);
        chk("rst_pc_imm", EX_pc_o | EX_imm_o, 32'h0);
        chk("rst_ctrl", {18'd0, EX_rd_add_o, EX_regwrite_o, EX_mem_op_o, EX_RD_mem_o,
                         EX_WR_mem_o, EX_sel_to_reg_o}, 32'h0);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        EX_valid_i = 1'b0;

        // Single-cycle ALU
        alu(5'd0,  32'd5,        32'h1234,     32'hFFFF_FFFD, 1'b1, 32'd2);
        alu(5'd1,  32'd10,       32'd3,        32'h0,         1'b0, 32'd7);
        alu(5'd2,  32'd1,        32'd31,       32'h0,         1'b0, 32'h8000_0000);
        alu(5'd2,  32'd1,        32'd33,       32'h0,         1'b0, 32'd2);
        alu(5'd7,  32'h8000_0000, 32'h0,       32'd4,         1'b1, 32'hF800_0000);
        alu(5'd6,  32'h8000_0000, 32'd4,       32'h0,         1'b0, 32'h0800_0000);
        alu(5'd4,  32'd1,        32'hFFFF_FFFF, 32'h0,        1'b0, 32'd1);
        alu(5'd3,  32'd1,        32'hFFFF_FFFF, 32'h0,        1'b0, 32'd0);
        alu(5'd5,  32'hF0F0,     32'hFF00,     32'h0,         1'b0, 32'h0FF0);
        alu(5'd8,  32'hF0F0,     32'h0F0F,     32'h0,         1'b0, 32'hFFFF);
        alu(5'd9,  32'hF0F0,     32'hFF00,     32'h0,         1'b0, 32'hF000);
        alu(5'd10, 32'd9,        32'd1,        32'hABCD_0000, 1'b1, 32'hABCD_0000);
        alu(5'd12, 32'd5,        32'd6,        32'h0,         1'b0, 32'd0);
        drive(5'd0, 3'd0, 2'd3, 2'd0, 1'b1, 32'd7, 32'd1, 32'h20, 32'h1000, 32'h0, 1'b1, 1'b0);
        push(32'h1020, 32'd1);

        // Multiply / divide
        md(5'd16, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE);
        alu(5'd0, 32'd1, 32'd1, 32'h0, 1'b0, 32'd2);
        md(5'd17, 32'hFFFF_FFFF, 32'd2,         32'd1);
        md(5'd16, 32'h1234_5678, 32'h10,        32'h2345_6780);
        md(5'd18, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD);
        md(5'd20, 32'd7,         32'hFFFF_FFFE, 32'd1);
        md(5'd19, 32'h1234,      32'd0,         32'hFFFF_FFFF);
        md(5'd21, 32'h1234,      32'd0,         32'h1234);
        md(5'd18, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        md(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        md(5'd18, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF);
        md(5'd20, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9);
        md(5'd20, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        md(5'd19, 32'd100,       32'd7,         32'd14);

        // Flush in the 10th CALC cycle: no result, FSM back to IDLE
        drive(5'd18, 3'd0, 2'd0, 2'd0, 1'b0, 32'd100, 32'd3, 32'h0, 32'h300, 32'h0, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        EX_flush_i = 1'b1;
        @(negedge clk);
        chk("busy_in_flush", {31'd0, EX_busy_o}, 32'd0);
        alu(5'd0, 32'd40, 32'd2, 32'h0, 1'b0, 32'd42);
        @(negedge clk);
        chk("busy_after_flush", {31'd0, EX_busy_o}, 32'd0);

        // Reset in the middle of a divide
        drive(5'd19, 3'd0, 2'd0, 2'd0, 1'b0, 32'd50, 32'd5, 32'h0, 32'h310, 32'h0, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n      = 1'b0;
        EX_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        alu(5'd1, 32'd50, 32'd8, 32'h0, 1'b0, 32'd42);
        @(negedge clk);
        chk("busy_after_reset", {31'd0, EX_busy_o}, 32'd0);

        // Forwarding and branches
        alu(5'd0, 32'd3, 32'd4, 32'h0, 1'b0, 32'd7);
        drive(5'd0, 3'd1, 2'd1, 2'd0, 1'b0, 32'h999, 32'd7, 32'h40, 32'h200, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("beq_fwd_taken", {31'd0, EX_br_taken_o}, 32'd1);
        chk("beq_target", EX_br_target_o, 32'h240);
        drive(5'd0, 3'd3, 2'd2, 2'd0, 1'b0, 32'd5, 32'd1, 32'h8, 32'h204, 32'hFFFF_FFFF, 1'b0, 1'b0);
        @(negedge clk);
        chk("blt_taken", {31'd0, EX_br_taken_o}, 32'd1);
        EX_br_op_i = 3'd5;
        #1;
        chk("bltu_not_taken", {31'd0, EX_br_taken_o}, 32'd0);
        EX_br_op_i = 3'd4;
        #1;
        chk("bge_not_taken", {31'd0, EX_br_taken_o}, 32'd0);
        drive(5'd0, 3'd0, 2'd0, 2'd2, 1'b1, 32'h100, 32'hDEAD, 32'd8, 32'h208, 32'h55, 1'b0, 1'b1);
        push(32'h108, 32'h55);
        drive(5'd0, 3'd0, 2'd0, 2'd1, 1'b0, 32'd1, 32'h0, 32'h0, 32'h20C, 32'h0, 1'b1, 1'b0);
        push(32'h109, 32'h108);

        // Branch suppressed while busy
        drive(5'd16, 3'd1, 2'd0, 2'd0, 1'b0, 32'd4, 32'd4, 32'h0, 32'h210, 32'h0, 1'b1, 1'b0);
        push(32'd16, 32'd4);
        @(negedge clk);
        chk("br_while_busy", {31'd0, EX_br_taken_o}, 32'd0);
        for (int c = 0; c < 40 && EX_busy_o; c++) @(negedge clk);

        idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
